// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - single-port memory bus between the arbiter and memory
interface mem_arbiter_if;
    logic        bus_req;
    logic        bus_rw;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_rw,
        output bus_addr,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_rw,
        input  bus_addr,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-priority fetch/data arbiter onto one memory port with timeout
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    input  logic              ex_mem_ena,
    input  logic              ex_mem_rw,
    input  logic [31:0]       ex_mem_addr,
    input  logic [31:0]       ex_mem_data,
    output logic              ex_valid,
    output logic [31:0]       ex_rdata,
    output logic              err_o,
    output logic              stall_o,
    mem_arbiter_if.master     bus
);
    typedef enum logic [1:0] {IDLE, EX_BUSY, IF_BUSY} state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic        bus_req_q;
    logic        bus_rw_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic        if_valid_q;
    logic        ex_valid_q;
    logic [31:0] if_rdata_q;
    logic [31:0] ex_rdata_q;
    logic        err_q;
    logic [7:0]  cnt_q;

    logic        ex_grant_d;
    logic        if_grant_d;
    logic        timeout_d;
    logic [7:0]  cnt_d;

    // A requester whose completion pulse is out this cycle is still holding its
    // request line; it must not be granted a second time for the same access.
    assign ex_grant_d = ex_mem_ena && !ex_valid_q;
    assign if_grant_d = if_req && !if_valid_q;
    assign timeout_d  = (cnt_q == CNT_LAST);
    assign cnt_d      = cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_rw_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            if_valid_q  <= 1'b0;
            ex_valid_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            ex_rdata_q  <= 32'd0;
            err_q       <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            if_valid_q <= 1'b0;
            ex_valid_q <= 1'b0;
            if_rdata_q <= 32'd0;
            ex_rdata_q <= 32'd0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_grant_d) begin
                        state_q     <= EX_BUSY;
                        bus_req_q   <= 1'b1;
                        bus_rw_q    <= ex_mem_rw;
                        bus_addr_q  <= ex_mem_addr;
                        bus_wdata_q <= ex_mem_data;
                        cnt_q       <= 8'd0;
                    end else if (if_grant_d) begin
                        state_q     <= IF_BUSY;
                        bus_req_q   <= 1'b1;
                        bus_rw_q    <= 1'b0;
                        bus_addr_q  <= if_addr;
                        bus_wdata_q <= 32'd0;
                        cnt_q       <= 8'd0;
                    end
                end
                EX_BUSY, IF_BUSY: begin
                    if (bus.bus_ack) begin
                        state_q   <= IDLE;
                        bus_req_q <= 1'b0;
                        if (state_q == EX_BUSY) begin
                            ex_valid_q <= 1'b1;
                            ex_rdata_q <= bus_rw_q ? 32'd0 : bus.bus_rdata;
                        end else begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= bus.bus_rdata;
                        end
                    end else if (timeout_d) begin
                        state_q   <= IDLE;
                        bus_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        if (state_q == EX_BUSY) begin
                            ex_valid_q <= 1'b1;
                        end else begin
                            if_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_rw    = bus_rw_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;

    assign if_valid = if_valid_q;
    assign if_rdata = if_rdata_q;
    assign ex_valid = ex_valid_q;
    assign ex_rdata = ex_rdata_q;
    assign err_o    = err_q;
    assign stall_o  = ex_mem_ena && !ex_valid_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - transaction-model scoreboard plus directed scenarios for mem_arbiter
module tb_mem_arbiter;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        ex_mem_ena;
    logic        ex_mem_rw;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_mem_data;
    logic        ex_valid;
    logic [31:0] ex_rdata;
    logic        err_o;
    logic        stall_o;

    mem_arbiter_if bus_if ();

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_valid    (if_valid),
        .if_rdata    (if_rdata),
        .ex_mem_ena  (ex_mem_ena),
        .ex_mem_rw   (ex_mem_rw),
        .ex_mem_addr (ex_mem_addr),
        .ex_mem_data (ex_mem_data),
        .ex_valid    (ex_valid),
        .ex_rdata    (ex_rdata),
        .err_o       (err_o),
        .stall_o     (stall_o),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction model: one outstanding access, its owner, and how long it has waited.
    bit          m_busy;
    bit          m_is_if;
    int          m_wait;
    bit          was_exv;
    bit          was_ifv;
    logic        e_req, e_rw, e_ifv, e_exv, e_err;
    logic [31:0] e_addr, e_wdata, e_ifd, e_exd;

    initial begin
        m_busy = 0; m_is_if = 0; m_wait = 0;
        e_req = 0; e_rw = 0; e_ifv = 0; e_exv = 0; e_err = 0;
        e_addr = 0; e_wdata = 0; e_ifd = 0; e_exd = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy = 0;
                e_req = 0; e_rw = 0; e_addr = 0; e_wdata = 0;
                e_ifv = 0; e_exv = 0; e_err = 0; e_ifd = 0; e_exd = 0;
            end else begin
                was_exv = e_exv;
                was_ifv = e_ifv;
                e_ifv = 0; e_exv = 0; e_err = 0; e_ifd = 0; e_exd = 0;
                if (!m_busy) begin
                    if (ex_mem_ena && !was_exv) begin
                        m_busy = 1; m_is_if = 0; m_wait = 0;
                        e_rw = ex_mem_rw; e_addr = ex_mem_addr; e_wdata = ex_mem_data;
                    end else if (if_req && !was_ifv) begin
                        m_busy = 1; m_is_if = 1; m_wait = 0;
                        e_rw = 0; e_addr = if_addr; e_wdata = 0;
                    end
                end else if (bus_if.bus_ack) begin
                    m_busy = 0;
                    if (m_is_if) begin
                        e_ifv = 1; e_ifd = bus_if.bus_rdata;
                    end else begin
                        e_exv = 1; e_exd = e_rw ? 32'd0 : bus_if.bus_rdata;
                    end
                end else begin
                    m_wait = m_wait + 1;
                    if (m_wait == TO) begin
                        m_busy = 0;
                        e_err = 1;
                        if (m_is_if) e_ifv = 1;
                        else         e_exv = 1;
                    end
                end
                e_req = m_busy;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("bus_req",  32'(bus_if.bus_req), 32'(e_req));
                chk("if_valid", 32'(if_valid), 32'(e_ifv));
                chk("ex_valid", 32'(ex_valid), 32'(e_exv));
                chk("err_o",    32'(err_o), 32'(e_err));
                chk("stall_o",  32'(stall_o), 32'(ex_mem_ena & ~e_exv));
                if (e_req) begin
                    chk("bus_rw",    32'(bus_if.bus_rw), 32'(e_rw));
                    chk("bus_addr",  bus_if.bus_addr, e_addr);
                    chk("bus_wdata", bus_if.bus_wdata, e_wdata);
                end
                if (e_ifv) chk("if_rdata", if_rdata, e_ifd);
                if (e_exv) chk("ex_rdata", ex_rdata, e_exd);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (count %0d)", n_bad);
        $fatal(1);
    end

    initial begin
        rst = 1; if_req = 0; if_addr = 0;
        ex_mem_ena = 0; ex_mem_rw = 0; ex_mem_addr = 0; ex_mem_data = 0;
        bus_if.bus_ack = 0; bus_if.bus_rdata = 0;
        cyc(); chk_en = 1;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_bus_req",  32'(bus_if.bus_req), 32'd0);
        chk("rst_bus_addr", bus_if.bus_addr, 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_err",      32'(err_o), 32'd0);
        cyc(); rst = 0;
        cyc();

        // fetch, acked on the second bus_req cycle
        if_req = 1; if_addr = 32'h100;
        cyc();
        cyc(); bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h13;
        @(negedge clk); chk("f_req2", 32'(bus_if.bus_req), 32'd1);
        cyc(); bus_if.bus_ack = 0; bus_if.bus_rdata = 0; if_req = 0;
        @(negedge clk);
        chk("f_valid", 32'(if_valid), 32'd1);
        chk("f_rdata", if_rdata, 32'h13);
        chk("f_req0",  32'(bus_if.bus_req), 32'd0);
        cyc();

        // collision: EX wins, fetch follows two cycles after the EX ack
        cyc(); if_req = 1; if_addr = 32'h200;
        ex_mem_ena = 1; ex_mem_rw = 0; ex_mem_addr = 32'h2000;
        cyc(); bus_if.bus_ack = 1; bus_if.bus_rdata = 32'hA5A5_5A5A;
        @(negedge clk); chk("c_addr_ex", bus_if.bus_addr, 32'h2000);
        cyc(); bus_if.bus_ack = 0; bus_if.bus_rdata = 0; ex_mem_ena = 0;
        @(negedge clk);
        chk("c_ex_valid", 32'(ex_valid), 32'd1);
        chk("c_ex_rdata", ex_rdata, 32'hA5A5_5A5A);
        chk("c_if_idle",  32'(if_valid), 32'd0);
        chk("c_gap",      32'(bus_if.bus_req), 32'd0);
        cyc(); bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h1111;
        @(negedge clk);
        chk("c_if_req",  32'(bus_if.bus_req), 32'd1);
        chk("c_if_addr", bus_if.bus_addr, 32'h200);
        cyc(); bus_if.bus_ack = 0; bus_if.bus_rdata = 0; if_req = 0;
        @(negedge clk);
        chk("c_if_valid", 32'(if_valid), 32'd1);
        chk("c_if_rdata", if_rdata, 32'h1111);

        // store
        cyc(); ex_mem_ena = 1; ex_mem_rw = 1; ex_mem_addr = 32'h3000; ex_mem_data = 32'hDEAD_BEEF;
        @(negedge clk); chk("s_stall0", 32'(stall_o), 32'd1);
        cyc();
        @(negedge clk);
        chk("s_rw",     32'(bus_if.bus_rw), 32'd1);
        chk("s_wdata",  bus_if.bus_wdata, 32'hDEAD_BEEF);
        chk("s_stall1", 32'(stall_o), 32'd1);
        cyc(); bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h1234_5678;
        cyc(); bus_if.bus_ack = 0; bus_if.bus_rdata = 0; ex_mem_ena = 0; ex_mem_rw = 0;
        @(negedge clk);
        chk("s_valid", 32'(ex_valid), 32'd1);
        chk("s_rdata", ex_rdata, 32'd0);

        // timeout: ack never arrives
        cyc(); ex_mem_ena = 1; ex_mem_addr = 32'h44; bus_if.bus_rdata = 32'hFFFF_FFFF;
        cyc(); cyc(); cyc(); cyc();
        @(negedge clk); chk("t_req_last", 32'(bus_if.bus_req), 32'd1);
        cyc(); ex_mem_ena = 0;
        @(negedge clk);
        chk("t_valid", 32'(ex_valid), 32'd1);
        chk("t_err",   32'(err_o), 32'd1);
        chk("t_rdata", ex_rdata, 32'd0);
        chk("t_req0",  32'(bus_if.bus_req), 32'd0);
        cyc(); bus_if.bus_rdata = 0;
        @(negedge clk); chk("t_err_pulse", 32'(err_o), 32'd0);

        // reset in the middle of a data access, then an ack while idle
        cyc(); ex_mem_ena = 1; ex_mem_addr = 32'h50;
        cyc(); rst = 1;
        @(negedge clk); chk("r_busy", 32'(bus_if.bus_req), 32'd1);
        cyc();
        @(negedge clk);
        chk("r_req0",  32'(bus_if.bus_req), 32'd0);
        chk("r_noval", 32'(ex_valid), 32'd0);
        chk("r_stall", 32'(stall_o), 32'd1);
        cyc(); rst = 0; ex_mem_ena = 0; bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h99;
        cyc(); bus_if.bus_ack = 0; bus_if.bus_rdata = 0;
        @(negedge clk);
        chk("r_idle_ack_ex", 32'(ex_valid), 32'd0);
        chk("r_idle_ack_if", 32'(if_valid), 32'd0);
        chk("r_idle_req",    32'(bus_if.bus_req), 32'd0);

        // requester inputs change while busy
        cyc(); ex_mem_ena = 1; ex_mem_rw = 0; ex_mem_addr = 32'h40; ex_mem_data = 32'h1;
        cyc(); ex_mem_addr = 32'h80; ex_mem_data = 32'h2; ex_mem_rw = 1;
        @(negedge clk);
        chk("i_addr1", bus_if.bus_addr, 32'h40);
        chk("i_rw1",   32'(bus_if.bus_rw), 32'd0);
        cyc(); bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h77;
        @(negedge clk); chk("i_addr2", bus_if.bus_addr, 32'h40);
        cyc(); bus_if.bus_ack = 0; bus_if.bus_rdata = 0; ex_mem_ena = 0; ex_mem_addr = 0; ex_mem_rw = 0;
        @(negedge clk);
        chk("i_valid", 32'(ex_valid), 32'd1);
        chk("i_rdata", ex_rdata, 32'h77);
        cyc(); cyc();
        @(negedge clk);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the number of busy cycles without bus_ack before a transaction is aborted (range 2..255).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port if_req  input  1  instruction-fetch read request, held until if_valid.
REQ-005 SHALL have port if_addr  input  32  fetch address.
REQ-006 SHALL have port if_valid  output  1  one-cycle pulse: fetch completed.
REQ-007 SHALL have port if_rdata  output  32  fetch data, meaningful while if_valid=1.
REQ-008 SHALL have port ex_mem_ena  input  1  data-access request from the EX stage, held until ex_valid.
REQ-009 SHALL have port ex_mem_rw  input  1  0 = MEM_READ, 1 = MEM_WRITE.
REQ-010 SHALL have port ex_mem_addr  input  32  data address.
REQ-011 SHALL have port ex_mem_data  input  32  write data.
REQ-012 SHALL have port ex_valid  output  1  one-cycle pulse: data access completed.
REQ-013 SHALL have port ex_rdata  output  32  load data, meaningful while ex_valid=1; 0 for writes.
REQ-014 SHALL have port err_o  output  1  one-cycle pulse coincident with if_valid/ex_valid when that transaction timed out.
REQ-015 SHALL have port stall_o  output  1  pipeline stall: ex_mem_ena=1 and ex_valid=0 in the same cycle (combinational).
REQ-016 SHALL have ports bus_req output 1, bus_rw output 1, bus_addr output 32, bus_wdata output 32: single-port memory request, all registered.
REQ-017 SHALL have ports bus_ack input 1 (transfer accepted/complete this cycle) and bus_rdata input 32 (read data, valid with bus_ack).

Function
REQ-018 SHALL implement FSM states IDLE, EX_BUSY, IF_BUSY.
REQ-019 In IDLE with ex_mem_ena=1, SHALL latch ex_mem_rw/addr/data and go to EX_BUSY, regardless of if_req (EX has strict priority).
REQ-020 In IDLE with ex_mem_ena=0 and if_req=1, SHALL latch if_addr, force bus_rw=0, go to IF_BUSY.
REQ-021 Request seen in IDLE at cycle N SHALL drive bus_req=1 from cycle N+1 with bus_rw/addr/wdata stable until the ack cycle.
REQ-022 Requester inputs changing during EX_BUSY/IF_BUSY SHALL be ignored; latched values are used.
REQ-023 bus_ack sampled 1 at cycle M in a busy state SHALL produce, at cycle M+1: bus_req=0, the matching valid pulse, rdata = bus_rdata captured at M (0 for writes), state IDLE.
REQ-024 The next grant decision SHALL occur in IDLE at M+1; next bus_req no earlier than M+2.
REQ-025 bus_ack while in IDLE SHALL be ignored (no valid, no state change).
REQ-026 An 8-bit busy counter SHALL clear on entering a busy state and increment each busy cycle with bus_ack=0; on reaching TIMEOUT_CYCLES, next cycle: bus_req=0, valid pulse with err_o=1, rdata=0, state IDLE.
REQ-027 if_valid and ex_valid SHALL never be asserted in the same cycle.
REQ-028 A continuously asserted ex_mem_ena MAY starve if_req; no fairness counter.

Reset
REQ-029 While rst=1 at a clock edge: state IDLE, bus_req=0, bus_rw=0, bus_addr=0, bus_wdata=0, if_valid=0, ex_valid=0, if_rdata=0, ex_rdata=0, err_o=0, counter=0.
REQ-030 rst asserted mid-transaction SHALL abort it: bus_req=0 next cycle, no valid or err_o pulse for the aborted access.
REQ-031 stall_o SHALL still follow REQ-015 during reset.

Verification
REQ-032 Fetch: if_req=1, if_addr=0x100, bus_ack at 2nd bus_req cycle with bus_rdata=0x00000013 -> if_valid=1, if_rdata=0x13 one cycle after ack, bus_req low that cycle.
REQ-033 Collision: if_req=1 and ex_mem_ena=1 (read 0x2000) same IDLE cycle -> EX served first, ex_valid before if_valid; fetch bus_req begins 2 cycles after EX ack.
REQ-034 Store: ex_mem_rw=1, addr=0x3000, data=0xDEADBEEF -> bus_rw=1, bus_wdata=0xDEADBEEF; ex_valid with ex_rdata=0; stall_o high from request until ex_valid cycle.
REQ-035 Timeout: TIMEOUT_CYCLES=4, read with bus_ack never asserted -> ex_valid=1, err_o=1, ex_rdata=0 after 4 busy cycles; FSM returns to IDLE.
REQ-036 Reset mid-op: rst=1 while EX_BUSY -> bus_req=0 next cycle, no ex_valid; later bus_ack ignored.
REQ-037 Input change: ex_mem_addr changed from 0x40 to 0x80 during EX_BUSY -> bus_addr stays 0x40 until ack.
